// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment display controller: sequential double-dabble BCD
// conversion into a display buffer, then a timed common-anode digit scan.
module seven_seg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned DATA_W       = 13,
   parameter int unsigned REFRESH_BITS = 18
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     value,
   input  logic                  load,
   input  logic                  blank_lz,
   output logic                  busy,
   output logic                  ovf,
   output logic [NUM_DIGITS-1:0] anode,
   output logic [6:0]            seg
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   localparam logic [6:0] SEG_OFF  = 7'b1111111;
   localparam logic [6:0] SEG_DASH = 7'b1111110;

   function automatic logic [63:0] pow10(input int unsigned n);
      logic [63:0] p;
      p = 64'd1;
      for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         default: return 7'b0000001;
      endcase
   endfunction

   logic                    busy_q, busy_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0]       shreg_q, shreg_d;
   logic [BCD_W-1:0]        bcd_q, bcd_d;
   logic                    ovf_pend_q, ovf_pend_d;
   logic                    blank_pend_q, blank_pend_d;
   logic [BCD_W-1:0]        buf_q, buf_d;
   logic                    blank_q, blank_d;
   logic                    ovf_q, ovf_d;
   logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic [6:0]              seg_q, seg_d;

   logic [BCD_W-1:0]        bcd_adj;
   logic [BCD_W-1:0]        bcd_step;
   logic [3:0]              cur_digit;
   logic                    upper_zero;
   logic                    blank_now;

   // One double-dabble iteration: add 3 to nibbles >= 5, then shift in the next value bit.
   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      bcd_step = {bcd_adj[BCD_W-2:0], shreg_q[DATA_W-1]};
   end

   // Load handshake and conversion sequencing; buffer, blank flag and ovf commit together.
   always_comb begin
      busy_d       = busy_q;
      cnt_d        = cnt_q;
      shreg_d      = shreg_q;
      bcd_d        = bcd_q;
      ovf_pend_d   = ovf_pend_q;
      blank_pend_d = blank_pend_q;
      buf_d        = buf_q;
      blank_d      = blank_q;
      ovf_d        = ovf_q;
      if (!busy_q) begin
         if (load) begin
            busy_d       = 1'b1;
            cnt_d        = '0;
            shreg_d      = value;
            bcd_d        = '0;
            ovf_pend_d   = (64'(value) >= OVF_LIMIT);
            blank_pend_d = blank_lz;
         end
      end else begin
         bcd_d   = bcd_step;
         shreg_d = shreg_q << 1;
         cnt_d   = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(DATA_W - 1)) begin
            busy_d  = 1'b0;
            buf_d   = bcd_step;
            blank_d = blank_pend_q;
            ovf_d   = ovf_pend_q;
         end
      end
   end

   // Scan timing and per-digit output selection; outputs register one clock behind idx_q.
   always_comb begin
      refresh_d = refresh_q + REFRESH_BITS'(1);
      idx_d     = idx_q;
      if (&refresh_q) begin
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end

      cur_digit  = '0;
      upper_zero = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) cur_digit = buf_q[4*i +: 4];
         if ((IDX_W'(i) >= idx_q) && (buf_q[4*i +: 4] != 4'd0)) upper_zero = 1'b0;
      end
      blank_now = blank_q && !ovf_q && (idx_q != '0) && upper_zero;

      anode_d = ~(NUM_DIGITS'(1) << idx_q);
      seg_d   = ovf_q ? SEG_DASH : seg_decode(cur_digit);
      if (blank_now) begin
         anode_d = '1;
         seg_d   = SEG_OFF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q       <= 1'b0;
         cnt_q        <= '0;
         shreg_q      <= '0;
         bcd_q        <= '0;
         ovf_pend_q   <= 1'b0;
         blank_pend_q <= 1'b0;
         buf_q        <= '0;
         blank_q      <= 1'b0;
         ovf_q        <= 1'b0;
         refresh_q    <= '0;
         idx_q        <= '0;
         anode_q      <= '1;
         seg_q        <= SEG_OFF;
      end else begin
         busy_q       <= busy_d;
         cnt_q        <= cnt_d;
         shreg_q      <= shreg_d;
         bcd_q        <= bcd_d;
         ovf_pend_q   <= ovf_pend_d;
         blank_pend_q <= blank_pend_d;
         buf_q        <= buf_d;
         blank_q      <= blank_d;
         ovf_q        <= ovf_d;
         refresh_q    <= refresh_d;
         idx_q        <= idx_d;
         anode_q      <= anode_d;
         seg_q        <= seg_d;
      end
   end

   assign busy  = busy_q;
   assign ovf   = ovf_q;
   assign anode = anode_q;
   assign seg   = seg_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: a 4-digit and a 3-digit instance
// share stimulus; expected segment patterns are written out by hand.
module tb_seven_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [12:0] value;
   logic        load;
   logic        blank_lz;

   logic        busy4, ovf4, busy3, ovf3;
   logic [3:0]  anode4;
   logic [2:0]  anode3;
   logic [6:0]  seg4, seg3;

   int checks   = 0;
   int failures = 0;

   localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
   localparam logic [6:0] S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0000100, SOFF = 7'b1111111, SDASH = 7'b1111110;

   logic [6:0] seg_seen4 [4];
   bit         seen4     [4];
   logic [6:0] seg_seen3 [3];
   bit         seen3     [3];
   int         blank_cnt, blank_bad;
   int         nbusy;

   always #5 clk = ~clk;

   seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DATA_W(13), .REFRESH_BITS(2)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
      .busy(busy4), .ovf(ovf4), .anode(anode4), .seg(seg4));

   seven_seg_scan_ctrl #(.NUM_DIGITS(3), .DATA_W(13), .REFRESH_BITS(2)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
      .busy(busy3), .ovf(ovf3), .anode(anode3), .seg(seg3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Watch a little more than one full scan and record what each digit slot showed.
   task automatic capture();
      for (int d = 0; d < 4; d++) begin seen4[d] = 0; seg_seen4[d] = 'x; end
      for (int d = 0; d < 3; d++) begin seen3[d] = 0; seg_seen3[d] = 'x; end
      blank_cnt = 0;
      blank_bad = 0;
      repeat (20) begin
         @(negedge clk);
         for (int d = 0; d < 4; d++) begin
            if (anode4 == 4'(~(4'b0001 << d))) begin seen4[d] = 1; seg_seen4[d] = seg4; end
         end
         for (int d = 0; d < 3; d++) begin
            if (anode3 == 3'(~(3'b001 << d))) begin seen3[d] = 1; seg_seen3[d] = seg3; end
         end
         if (anode4 == 4'hF) begin
            blank_cnt++;
            if (seg4 != SOFF) blank_bad++;
         end
      end
   endtask

   // Issue a load, count busy cycles; optionally pulse a second load or assert reset mid-busy.
   task automatic run_load(input logic [12:0] v, input logic blz, input int pulse_at,
                           input int abort_at, output int nb);
      @(posedge clk);
      #1 value = v; blank_lz = blz; load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      nb = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (busy4 !== 1'b1) break;
         nb++;
         if (nb == pulse_at) begin value = 13'd1111; load = 1'b1; end
         else if (nb == pulse_at + 1) load = 1'b0;
         if (nb == abort_at) begin rst_n = 1'b0; break; end
      end
   endtask

   task automatic settle();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; value = '0; load = 1'b0; blank_lz = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_anode4", 32'(anode4), 32'hF);
      chk("rst_seg4",   32'(seg4),   32'(SOFF));
      chk("rst_busy4",  32'(busy4),  32'd0);
      chk("rst_ovf4",   32'(ovf4),   32'd0);
      chk("rst_anode3", 32'(anode3), 32'h7);

      // Scan after release: each digit dwells 4 clocks and shows "0".
      rst_n = 1'b1;
      @(negedge clk);
      chk("scan0_anode", 32'(anode4), 32'b1110);
      chk("scan0_seg",   32'(seg4),   32'(S0));
      repeat (4) @(negedge clk);
      chk("scan1_anode", 32'(anode4), 32'b1101);
      chk("scan1_seg",   32'(seg4),   32'(S0));
      repeat (4) @(negedge clk);
      chk("scan2_anode", 32'(anode4), 32'b1011);
      chk("scan2_seg",   32'(seg4),   32'(S0));
      repeat (4) @(negedge clk);
      chk("scan3_anode", 32'(anode4), 32'b0111);
      chk("scan3_seg",   32'(seg4),   32'(S0));
      repeat (4) @(negedge clk);
      chk("scan_wrap_anode", 32'(anode4), 32'b1110);

      // 1234, no blanking.
      run_load(13'd1234, 1'b0, -1, -1, nbusy);
      chk("busy_len_1234", 32'(nbusy), 32'd13);
      settle();
      capture();
      chk("d0_1234", 32'(seg_seen4[0]), 32'(S4));
      chk("d1_1234", 32'(seg_seen4[1]), 32'(S3));
      chk("d2_1234", 32'(seg_seen4[2]), 32'(S2));
      chk("d3_1234", 32'(seg_seen4[3]), 32'(S1));
      chk("ovf_1234", 32'(ovf4), 32'd0);
      chk("blankcnt_1234", 32'(blank_cnt), 32'd0);

      // 42 with leading-zero blanking.
      run_load(13'd42, 1'b1, -1, -1, nbusy);
      chk("busy_len_42", 32'(nbusy), 32'd13);
      settle();
      capture();
      chk("seen3_42", 32'(seen4[3]), 32'd0);
      chk("seen2_42", 32'(seen4[2]), 32'd0);
      chk("d1_42", 32'(seg_seen4[1]), 32'(S4));
      chk("d0_42", 32'(seg_seen4[0]), 32'(S2));
      chk("blank_seg_42", 32'(blank_bad), 32'd0);
      chk("blank_seen_42", 32'(blank_cnt > 0), 32'd1);

      // 0 with blanking: single "0" on digit 0.
      run_load(13'd0, 1'b1, -1, -1, nbusy);
      settle();
      capture();
      chk("seen0_zero", 32'(seen4[0]), 32'd1);
      chk("d0_zero",    32'(seg_seen4[0]), 32'(S0));
      chk("seen1_zero", 32'(seen4[1]), 32'd0);
      chk("seen2_zero", 32'(seen4[2]), 32'd0);
      chk("seen3_zero", 32'(seen4[3]), 32'd0);
      chk("blank_seg_zero", 32'(blank_bad), 32'd0);

      // 8191: fits in 4 digits, overflows 3 digits.
      run_load(13'd8191, 1'b0, -1, -1, nbusy);
      chk("busy_len_8191", 32'(nbusy), 32'd13);
      settle();
      capture();
      chk("d0_8191", 32'(seg_seen4[0]), 32'(S1));
      chk("d1_8191", 32'(seg_seen4[1]), 32'(S9));
      chk("d2_8191", 32'(seg_seen4[2]), 32'(S1));
      chk("d3_8191", 32'(seg_seen4[3]), 32'(S8));
      chk("ovf4_8191", 32'(ovf4), 32'd0);
      chk("ovf3_8191", 32'(ovf3), 32'd1);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("dash%0d_8191", d), 32'(seg_seen3[d]), 32'(SDASH));
         chk($sformatf("seen3_%0d_8191", d), 32'(seen3[d]), 32'd1);
      end

      // 5678 with an ignored mid-busy load of 1111.
      run_load(13'd5678, 1'b0, 5, -1, nbusy);
      chk("busy_len_5678", 32'(nbusy), 32'd13);
      settle();
      capture();
      chk("d0_5678", 32'(seg_seen4[0]), 32'(S8));
      chk("d1_5678", 32'(seg_seen4[1]), 32'(S7));
      chk("d2_5678", 32'(seg_seen4[2]), 32'(S6));
      chk("d3_5678", 32'(seg_seen4[3]), 32'(S5));
      chk("ovf4_5678", 32'(ovf4), 32'd0);
      chk("ovf3_5678", 32'(ovf3), 32'd1);

      // Second conversion aborted by reset at busy cycle 8.
      run_load(13'd1234, 1'b0, -1, 8, nbusy);
      chk("abort_point", 32'(nbusy), 32'd8);
      #1;
      chk("abort_anode4", 32'(anode4), 32'hF);
      chk("abort_seg4",   32'(seg4),   32'(SOFF));
      chk("abort_busy4",  32'(busy4),  32'd0);
      chk("abort_ovf3",   32'(ovf3),   32'd0);
      chk("abort_anode3", 32'(anode3), 32'h7);
      settle();
      rst_n = 1'b1;
      settle();
      capture();
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("post_abort_d%0d", d), 32'(seg_seen4[d]), 32'(S0));
         chk($sformatf("post_abort_seen%0d", d), 32'(seen4[d]), 32'd1);
      end
      chk("post_abort_busy", 32'(busy4), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
